// File: rtl/mig_ui_pkg.sv
// Shared MIG user-interface definitions for the DDR4 read/write engines.
package mig_ui_pkg;

    localparam logic [2:0]  MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0]  MIG_CMD_READ  = 3'b001;

    localparam int unsigned MIG_ADDR_W = 29;
    localparam int unsigned MIG_DATA_W = 512;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } wr_state_e;

endpackage

// File: rtl/mig_addr_wrap.sv
// Next-beat address with optional ring-region wrap; purely combinational so the
// read engine can reuse it.
module mig_addr_wrap #(
    parameter int unsigned ADDR_W    = 29,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] wrap_lo,
    input  logic [ADDR_W-1:0] wrap_hi,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W:0] STEP_EXT = (ADDR_W+1)'(ADDR_STEP);

    logic [ADDR_W:0] sum;
    logic [ADDR_W:0] hi_ext;
    logic [ADDR_W:0] excess;

    always_comb begin
        sum    = {1'b0, addr} + STEP_EXT;
        hi_ext = {1'b0, wrap_hi};
        excess = sum - hi_ext;
        // The extra carry bit lets a ring ending at the top of the space still wrap.
        if ((wrap_hi != '0) && (sum >= hi_ext)) begin
            next_addr = wrap_lo + excess[ADDR_W-1:0];
        end else begin
            next_addr = sum[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/mig_wr_burst_engine.sv
// DDR4 MIG write engine: one burst per command, data and command channels run
// independently with data allowed at most MAX_LEAD beats ahead of commands.
module mig_wr_burst_engine
    import mig_ui_pkg::*;
#(
    parameter int unsigned ADDR_W    = MIG_ADDR_W,
    parameter int unsigned DATA_W    = MIG_DATA_W,
    parameter int unsigned MASK_W    = DATA_W / 8,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ADDR_STEP = 8,
    parameter int unsigned MAX_LEAD  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [MASK_W-1:0] cmd_mask,
    input  logic [ADDR_W-1:0] wrap_lo,
    input  logic [ADDR_W-1:0] wrap_hi,
    output logic              busy,
    output logic              done,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_rd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask
);

    localparam logic [LEN_W:0] LEAD_CAP = (LEN_W+1)'(MAX_LEAD);

    wr_state_e         state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    len_ext;
    logic [LEN_W:0]    data_cnt;
    logic [LEN_W:0]    cmd_cnt;
    logic [LEN_W:0]    lead;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] next_addr;
    logic [MASK_W-1:0] mask_q;
    logic              run;
    logic              data_go;
    logic              cmd_go;
    logic              last_cmd;

    mig_addr_wrap #(
        .ADDR_W   (ADDR_W),
        .ADDR_STEP(ADDR_STEP)
    ) u_addr_wrap (
        .addr     (addr_q),
        .wrap_lo  (wrap_lo),
        .wrap_hi  (wrap_hi),
        .next_addr(next_addr)
    );

    assign run     = (state == StRun);
    assign len_ext = {1'b0, len_q};
    assign lead    = data_cnt - cmd_cnt;

    assign app_wdf_wren = run && src_valid && (data_cnt < len_ext) && (lead < LEAD_CAP);
    assign data_go      = app_wdf_wren && app_wdf_rdy;

    // Depends only on registered counters, never on app_rdy.
    assign app_en   = run && (cmd_cnt < data_cnt);
    assign cmd_go   = app_en && app_rdy;
    assign last_cmd = cmd_go && (cmd_cnt == (len_ext - 1'b1));

    assign src_rd       = data_go;
    assign app_cmd      = MIG_CMD_WRITE;
    assign app_addr     = addr_q;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = src_data;
    assign app_wdf_mask = mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            len_q     <= '0;
            mask_q    <= '0;
            addr_q    <= '0;
            data_cnt  <= '0;
            cmd_cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_start) begin
                        cmd_ready <= 1'b0;
                        if (cmd_len != '0) begin
                            len_q    <= cmd_len;
                            mask_q   <= cmd_mask;
                            addr_q   <= cmd_addr;
                            data_cnt <= '0;
                            cmd_cnt  <= '0;
                            busy     <= 1'b1;
                            state    <= StRun;
                        end else begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StRun: begin
                    if (data_go) begin
                        data_cnt <= data_cnt + 1'b1;
                    end
                    if (cmd_go) begin
                        cmd_cnt <= cmd_cnt + 1'b1;
                        addr_q  <= next_addr;
                    end
                    if (last_cmd) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    cmd_ready <= 1'b1;
                    state     <= StIdle;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mig_wr_burst_engine.sv
// Bench for mig_wr_burst_engine: transaction-level model of the burst rules,
// checked every cycle, plus directed scenarios pinned by literal expectations.
module tb_mig_wr_burst_engine;

    localparam int ADDR_W   = 29;
    localparam int DATA_W   = 512;
    localparam int MASK_W   = 64;
    localparam int LEN_W    = 8;
    localparam int STEP     = 8;
    localparam int MAX_LEAD = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_start;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [MASK_W-1:0] cmd_mask;
    logic [ADDR_W-1:0] wrap_lo;
    logic [ADDR_W-1:0] wrap_hi;
    logic              busy;
    logic              done;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_rd;
    logic              app_en;
    logic              app_rdy;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;

    mig_wr_burst_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MASK_W   (MASK_W),
        .LEN_W    (LEN_W),
        .ADDR_STEP(STEP),
        .MAX_LEAD (MAX_LEAD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_mask    (cmd_mask),
        .wrap_lo     (wrap_lo),
        .wrap_hi     (wrap_hi),
        .busy        (busy),
        .done        (done),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_rd      (src_rd),
        .app_en      (app_en),
        .app_rdy     (app_rdy),
        .app_cmd     (app_cmd),
        .app_addr    (app_addr),
        .app_wdf_wren(app_wdf_wren),
        .app_wdf_end (app_wdf_end),
        .app_wdf_rdy (app_wdf_rdy),
        .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Source FIFO and channel-ready shaping.
    logic [DATA_W-1:0] fifo_q[$];
    bit valid_gate;
    bit toggle_ph;
    bit pop_flag;
    int valid_mode;
    int valid_pct;
    int rdy_pct;
    int wdf_pct;
    int rdy_hold;

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic drive_src();
        src_valid = valid_gate && (fifo_q.size() > 0);
        src_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_flag = 1'b0;
        while (fifo_q.size() < 6) fifo_q.push_back(rand_word());
        toggle_ph = !toggle_ph;
        case (valid_mode)
            0:       valid_gate = 1'b1;
            1:       valid_gate = ($urandom_range(99) < valid_pct);
            default: valid_gate = toggle_ph;
        endcase
        if (rdy_hold > 0) begin
            app_rdy = 1'b0;
            rdy_hold--;
        end else begin
            app_rdy = ($urandom_range(99) < rdy_pct);
        end
        app_wdf_rdy = ($urandom_range(99) < wdf_pct);
        drive_src();
    endtask

    // Reference: address of the beat after a, from the ring rules.
    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
        longint n;
        logic [63:0] t;
        n = longint'(a) + STEP;
        if (wrap_hi != 0 && n >= longint'(wrap_hi)) n = longint'(wrap_lo) + (n - longint'(wrap_hi));
        t = 64'(n);
        return t[ADDR_W-1:0];
    endfunction

    // Transaction-level model: phase 0 idle, 1 burst active, 2 done pulse.
    int m_phase = 0;
    int m_len, m_dcnt, m_ccnt;
    logic [ADDR_W-1:0] m_addr;
    logic [MASK_W-1:0] m_mask;
    logic [ADDR_W-1:0] addr_log[$];
    int cyc = 0, start_cyc, done_cyc, last_cmd_cyc, rdy_rise_cyc;
    int done_cnt, pop_cnt, en_cnt, wren_cnt, max_lead;
    bit prev_ready = 1'b1;

    always @(negedge clk) begin
        bit e_wren, e_en;
        cyc++;
        if (!rst_n) begin
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_app_en", app_en, 0);
            chk("rst_wren", app_wdf_wren, 0);
            chk("rst_src_rd", src_rd, 0);
            chk("rst_app_addr", app_addr, 0);
            chk("rst_mask", app_wdf_mask, 0);
            m_phase  = 0;
            m_dcnt   = 0;
            m_ccnt   = 0;
            pop_flag = 1'b0;
        end else begin
            e_wren = (m_phase == 1) && src_valid && (m_dcnt < m_len) &&
                     ((m_dcnt - m_ccnt) < MAX_LEAD);
            e_en   = (m_phase == 1) && (m_ccnt < m_dcnt);
            chk("cmd_ready", cmd_ready, m_phase == 0);
            chk("busy", busy, m_phase == 1);
            chk("done", done, m_phase == 2);
            chk("app_wdf_wren", app_wdf_wren, e_wren);
            chk("app_wdf_end", app_wdf_end, e_wren);
            chk("app_en", app_en, e_en);
            chk("src_rd", src_rd, e_wren && app_wdf_rdy);
            chk("app_cmd", app_cmd, 3'b000);
            if (e_en) chk("app_addr", app_addr, m_addr);
            if (e_wren) begin
                chk("wdf_data", app_wdf_data, fifo_q[0]);
                chk("wdf_mask", app_wdf_mask, m_mask);
            end

            if (cmd_ready && !prev_ready) rdy_rise_cyc = cyc;
            prev_ready = cmd_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (src_rd) pop_cnt++;
            if (app_en) en_cnt++;
            if (app_wdf_wren) wren_cnt++;
            pop_flag = src_rd;

            case (m_phase)
                0: if (cmd_start) begin
                    start_cyc = cyc;
                    if (cmd_len == 0) begin
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                        m_len   = int'(cmd_len);
                        m_addr  = cmd_addr;
                        m_mask  = cmd_mask;
                        m_dcnt  = 0;
                        m_ccnt  = 0;
                    end
                end
                1: begin
                    if (e_wren && app_wdf_rdy) m_dcnt++;
                    if (e_en && app_rdy) begin
                        addr_log.push_back(m_addr);
                        m_addr = nxt(m_addr);
                        m_ccnt++;
                        if (m_ccnt == m_len) begin
                            m_phase      = 2;
                            last_cmd_cyc = cyc;
                        end
                    end
                    if (m_dcnt - m_ccnt > max_lead) max_lead = m_dcnt - m_ccnt;
                end
                default: m_phase = 0;
            endcase
        end
    end

    function automatic logic [ADDR_W-1:0] log_at(input int i);
        return (i < addr_log.size()) ? addr_log[i] : '1;
    endfunction

    task automatic clear_stats();
        addr_log.delete();
        done_cnt = 0;
        pop_cnt  = 0;
        en_cnt   = 0;
        wren_cnt = 0;
        max_lead = 0;
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] a, input int len,
                               input logic [MASK_W-1:0] m);
        int budget = 3000;
        while (m_phase != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout_fail("start_wait");
        cmd_addr  = a;
        cmd_len   = LEN_W'(len);
        cmd_mask  = m;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget = 3000;
        while (m_phase != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout_fail(name);
    endtask

    initial begin
        logic [ADDR_W-1:0] wexp [5];
        logic [ADDR_W-1:0] a, lo, hi;
        int len;

        rst_n = 1'b0; cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_mask = '0;
        wrap_lo = '0; wrap_hi = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        valid_mode = 0; valid_pct = 100; rdy_pct = 100; wdf_pct = 100; rdy_hold = 0;
        valid_gate = 1'b1; toggle_ph = 1'b0; pop_flag = 1'b0;
        while (fifo_q.size() < 6) fifo_q.push_back(rand_word());
        drive_src();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic 4-beat burst.
        clear_stats();
        start_burst(29'h100, 4, '0);
        wait_idle("t1_idle");
        repeat (2) tick();
        chk("t1_cmds", 32'(addr_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("t1_addr", log_at(i), 29'h100 + 29'(8 * i));
        chk("t1_wren_beats", 32'(wren_cnt), 4);
        chk("t1_done_pulses", 32'(done_cnt), 1);
        chk("t1_ready_gap", 32'(rdy_rise_cyc - last_cmd_cyc), 2);

        // Command channel stalled: data must stop at the lead cap.
        clear_stats();
        rdy_hold = 11;
        start_burst(29'h2000, 8, 64'hF0F0);
        repeat (10) tick();
        chk("t2_popped_stalled", 32'(pop_cnt), MAX_LEAD);
        chk("t2_wren_blocked", app_wdf_wren, 0);
        wait_idle("t2_idle");
        chk("t2_cmds", 32'(addr_log.size()), 8);
        for (int i = 0; i < 8; i++) chk("t2_addr", log_at(i), 29'h2000 + 29'(8 * i));
        chk("t2_max_lead", 32'(max_lead), MAX_LEAD);

        // Source valid toggling every cycle.
        clear_stats();
        valid_mode = 2;
        start_burst(29'h300, 6, 64'hDEAD_BEEF_0000_0001);
        wait_idle("t3_idle");
        valid_mode = 0;
        chk("t3_cmds", 32'(addr_log.size()), 6);
        chk("t3_pops", 32'(pop_cnt), 6);

        // Ring wrap.
        clear_stats();
        wrap_lo = 29'h1000;
        wrap_hi = 29'h1020;
        wexp = '{29'h1010, 29'h1018, 29'h1000, 29'h1008, 29'h1010};
        start_burst(29'h1010, 5, '0);
        wait_idle("t4_idle");
        for (int i = 0; i < 5; i++) chk("t4_wrap_addr", log_at(i), wexp[i]);
        wrap_lo = '0;
        wrap_hi = '0;

        // Zero-length burst.
        clear_stats();
        start_burst(29'h400, 0, '1);
        repeat (3) tick();
        chk("t5_done_latency", 32'(done_cyc - start_cyc), 1);
        chk("t5_done_pulses", 32'(done_cnt), 1);
        chk("t5_no_app_en", 32'(en_cnt), 0);
        chk("t5_no_wren", 32'(wren_cnt), 0);

        // cmd_start while busy is ignored.
        clear_stats();
        start_burst(29'h500, 3, '0);
        cmd_start = 1'b1;
        cmd_addr  = 29'h900;
        cmd_len   = 8'd7;
        repeat (2) tick();
        cmd_start = 1'b0;
        wait_idle("t5b_idle");
        chk("t5b_cmds", 32'(addr_log.size()), 3);
        for (int i = 0; i < 3; i++) chk("t5b_addr", log_at(i), 29'h500 + 29'(8 * i));

        // Reset in the middle of a burst.
        clear_stats();
        start_burst(29'h600, 8, 64'h55);
        begin
            int budget = 100;
            while (m_dcnt < 2 && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) timeout_fail("t6_third_beat");
        end
        rst_n = 1'b0;
        #1;
        chk("t6_async_cmd_ready", cmd_ready, 1);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_app_en", app_en, 0);
        chk("t6_async_wren", app_wdf_wren, 0);
        chk("t6_async_addr", app_addr, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", 32'(done_cnt), 0);
        clear_stats();
        start_burst(29'h700, 4, '0);
        wait_idle("t6_idle");
        chk("t6_cmds", 32'(addr_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("t6_addr", log_at(i), 29'h700 + 29'(8 * i));

        // Top-of-space truncation without wrap.
        clear_stats();
        start_burst(29'h1FFF_FFF0, 4, '0);
        wait_idle("t7_idle");
        chk("t7_addr2", log_at(2), 29'h0);
        chk("t7_addr3", log_at(3), 29'h8);

        // Randomized bursts with random stalls and ring configurations.
        valid_mode = 1;
        for (int n = 0; n < 30; n++) begin
            valid_pct = $urandom_range(100, 40);
            rdy_pct   = $urandom_range(100, 30);
            wdf_pct   = $urandom_range(100, 30);
            len = ($urandom_range(3) == 0) ? $urandom_range(60, 1) : $urandom_range(16, 1);
            if ($urandom_range(1) == 1) begin
                lo = 29'h8000 + 29'(8 * $urandom_range(64));
                hi = lo + 29'(8 * $urandom_range(12, 2));
                a  = ($urandom_range(4) == 0) ? lo - 29'd16
                                              : lo + 29'(8 * $urandom_range((hi - lo) / 8 - 1));
            end else begin
                lo = '0;
                hi = '0;
                a  = ($urandom_range(3) == 0) ? 29'h1FFF_FFE0 : 29'(8 * $urandom_range(4096));
            end
            wrap_lo = lo;
            wrap_hi = hi;
            clear_stats();
            start_burst(a, len, {$urandom(), $urandom()});
            wait_idle("rand_idle");
            chk("rand_cmds", 32'(addr_log.size()), 32'(len));
            chk("rand_done", 32'(done_cnt), 1);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d errors so far", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
